o_scope_sample_sequencer: RTL and testbench

Avalon-MM master that programs and services the o-scope sample timer slave. On a host start command it loads the 32-bit period, starts the timer in continuous interrupt mode, acknowledges each timeout interrupt, and emits one sample strobe per timeout. After the requested sample count, or on abort, it stops the timer. It sits between the capture control registers and the timer slave, and is the only master on that slave.

---
 rtl/o_scope_pkg.sv | 37 +++
 rtl/o_scope_sample_sequencer.sv | 149 ++++++++++++++
 tb/tb_o_scope_sample_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/o_scope_pkg.sv
// rtl/o_scope_pkg.sv - shared constants and state encoding for the o-scope sample sequencer
package o_scope_pkg;

    // Timer slave word addresses
    localparam logic [2:0] TMR_STATUS   = 3'd0;
    localparam logic [2:0] TMR_CONTROL  = 3'd1;
    localparam logic [2:0] TMR_PERIOD_L = 3'd2;
    localparam logic [2:0] TMR_PERIOD_H = 3'd3;

    // Timer control register bit positions
    localparam int CTL_ITO_BIT   = 0;
    localparam int CTL_CONT_BIT  = 1;
    localparam int CTL_START_BIT = 2;
    localparam int CTL_STOP_BIT  = 3;

    // START + CONT + ITO: continuous interrupt mode
    localparam logic [15:0] CTL_START_WORD = 16'h0007;
    // STOP with ITO cleared so a late timeout cannot raise the irq
    localparam logic [15:0] CTL_STOP_WORD  = 16'h0008;

    // Shortest period the sequencer can service without the ACK write
    // colliding with the next timeout
    localparam logic [31:0] MIN_PERIOD_DEFAULT = 32'd4;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_PL    = 4'd1,
        ST_WR_PH    = 4'd2,
        ST_SETTLE   = 4'd3,
        ST_WR_START = 4'd4,
        ST_RUN      = 4'd5,
        ST_ACK      = 4'd6,
        ST_WR_STOP  = 4'd7,
        ST_FIN      = 4'd8
    } seq_state_t;

endpackage

// File: rtl/o_scope_sample_sequencer.sv
// rtl/o_scope_sample_sequencer.sv - Avalon-MM master that programs the sample timer and emits one strobe per timeout
module o_scope_sample_sequencer
    import o_scope_pkg::*;
#(
    parameter int          CNT_W      = 16,
    parameter logic [31:0] MIN_PERIOD = MIN_PERIOD_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      cfg_period,
    input  logic [CNT_W-1:0] cfg_num_samples,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             cfg_error,
    output logic             sample_strobe,
    output logic [CNT_W-1:0] sample_index,
    output logic [2:0]       tmr_address,
    output logic             tmr_chipselect,
    output logic             tmr_write_n,
    output logic [15:0]      tmr_writedata,
    input  logic             tmr_irq
);

    seq_state_t       r_state;
    logic [31:0]      r_period;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_count;
    logic             r_aborted;
    logic             r_cfg_error;

    logic [CNT_W-1:0] w_count_next;
    logic             w_abort_take;
    logic             w_last_sample;

    assign w_count_next  = r_count + 1'b1;
    assign w_last_sample = (r_num != '0) && (w_count_next == r_num);
    // Once the stop write is committed (or the capture is over) abort has nothing left to cut short
    assign w_abort_take  = abort && (r_state != ST_IDLE) && (r_state != ST_FIN)
                                 && (r_state != ST_WR_STOP);

    // Sequencer state, latched configuration and sample count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_period    <= '0;
            r_num       <= '0;
            r_count     <= '0;
            r_aborted   <= 1'b0;
            r_cfg_error <= 1'b0;
        end else begin
            r_cfg_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_period < MIN_PERIOD) begin
                            r_cfg_error <= 1'b1;
                        end else begin
                            r_period  <= cfg_period;
                            r_num     <= cfg_num_samples;
                            r_count   <= '0;
                            r_aborted <= 1'b0;
                            r_state   <= ST_WR_PL;
                        end
                    end
                end
                ST_WR_PL:    r_state <= ST_WR_PH;
                ST_WR_PH:    r_state <= ST_SETTLE;
                ST_SETTLE:   r_state <= ST_WR_START;
                ST_WR_START: r_state <= ST_RUN;
                ST_RUN: begin
                    if (tmr_irq) begin
                        r_state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_count <= w_count_next;
                    r_state <= w_last_sample ? ST_WR_STOP : ST_RUN;
                end
                ST_WR_STOP:  r_state <= ST_FIN;
                ST_FIN:      r_state <= ST_IDLE;
                default:     r_state <= ST_IDLE;
            endcase

            // Abort overrides whatever the state step chose, including a pending irq
            if (w_abort_take) begin
                r_state   <= ST_WR_STOP;
                r_aborted <= 1'b1;
            end
        end
    end

    // Bus master outputs decoded purely from the registered state
    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = TMR_STATUS;
        tmr_writedata  = 16'h0000;
        case (r_state)
            ST_WR_PL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = TMR_PERIOD_L;
                tmr_writedata  = r_period[15:0];
            end
            ST_WR_PH: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = TMR_PERIOD_H;
                tmr_writedata  = r_period[31:16];
            end
            ST_WR_START: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = TMR_CONTROL;
                tmr_writedata  = CTL_START_WORD;
            end
            ST_ACK: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = TMR_STATUS;
                tmr_writedata  = 16'h0000;
            end
            ST_WR_STOP: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = TMR_CONTROL;
                tmr_writedata  = CTL_STOP_WORD;
            end
            default: begin
                tmr_chipselect = 1'b0;
                tmr_write_n    = 1'b1;
                tmr_address    = TMR_STATUS;
                tmr_writedata  = 16'h0000;
            end
        endcase
    end

    // Status and sample outputs
    assign busy          = (r_state != ST_IDLE);
    assign done          = (r_state == ST_FIN) && !r_aborted;
    assign aborted       = (r_state == ST_FIN) && r_aborted;
    assign cfg_error     = r_cfg_error;
    assign sample_strobe = (r_state == ST_ACK);
    assign sample_index  = (r_state == ST_ACK) ? r_count : '0;

endmodule

// File: tb/tb_o_scope_sample_sequencer.sv
// tb/tb_o_scope_sample_sequencer.sv - directed self-checking bench for o_scope_sample_sequencer
module tb_o_scope_sample_sequencer;

    localparam int CW = 4;

    typedef struct packed {
        int          c;
        logic [2:0]  a;
        logic [15:0] d;
    } wr_t;

    typedef struct packed {
        int          c;
        logic [CW-1:0] idx;
    } stb_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   cfg_period = '0;
    logic [CW-1:0] cfg_num_samples = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, aborted, cfg_error, sample_strobe;
    logic [CW-1:0] sample_index;
    logic [2:0]    tmr_address;
    logic          tmr_chipselect, tmr_write_n;
    logic [15:0]   tmr_writedata;
    logic          tmr_irq;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;

    wr_t  got_w[$], exp_w[$];
    stb_t got_s[$], exp_s[$];
    int   got_done[$], exp_done[$];
    int   got_abt[$], exp_abt[$];
    int   got_err[$], exp_err[$];
    int   busy_cnt = 0;

    o_scope_sample_sequencer #(.CNT_W(CW), .MIN_PERIOD(32'd4)) dut (
        .clk(clk), .reset(reset),
        .cfg_period(cfg_period), .cfg_num_samples(cfg_num_samples),
        .start(start), .abort(abort),
        .busy(busy), .done(done), .aborted(aborted), .cfg_error(cfg_error),
        .sample_strobe(sample_strobe), .sample_index(sample_index),
        .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
        .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
        .tmr_irq(tmr_irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Timer slave model: bus sampled at negedge, applied at the following posedge
    logic        s_wr = 1'b0;
    logic [2:0]  s_a = '0;
    logic [15:0] s_d = '0;
    logic [31:0] tm_period = '0, tm_cnt = '0;
    logic        tm_run = 1'b0, tm_to = 1'b0, tm_ito = 1'b0;

    assign tmr_irq = tm_to & tm_ito;

    always @(negedge clk) begin
        s_wr = tmr_chipselect & ~tmr_write_n;
        s_a  = tmr_address;
        s_d  = tmr_writedata;
    end

    always @(posedge clk) begin
        if (reset) begin
            tm_period <= '0; tm_cnt <= '0; tm_run <= 1'b0; tm_to <= 1'b0; tm_ito <= 1'b0;
        end else begin
            if (tm_run) begin
                if (tm_cnt == 0) begin
                    tm_to  <= 1'b1;
                    tm_cnt <= tm_period;
                end else begin
                    tm_cnt <= tm_cnt - 1;
                end
            end
            if (s_wr) begin
                case (s_a)
                    3'd0: tm_to <= 1'b0;
                    3'd1: begin
                        tm_ito <= s_d[0];
                        if (s_d[3]) tm_run <= 1'b0;
                        if (s_d[2]) begin
                            tm_run <= 1'b1;
                            tm_cnt <= tm_period;
                        end
                    end
                    3'd2: tm_period[15:0]  <= s_d;
                    3'd3: tm_period[31:16] <= s_d;
                    default: ;
                endcase
            end
        end
    end

    // Event monitor, cycle numbers relative to the start cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (tmr_chipselect && !tmr_write_n) got_w.push_back('{cyc - t0, tmr_address, tmr_writedata});
            if (sample_strobe) got_s.push_back('{cyc - t0, sample_index});
            if (done)      got_done.push_back(cyc - t0);
            if (aborted)   got_abt.push_back(cyc - t0);
            if (cfg_error) got_err.push_back(cyc - t0);
            if (busy)      busy_cnt = busy_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int c);
        do step(); while (cyc != t0 + c);
    endtask

    task automatic clear_logs();
        got_w.delete(); exp_w.delete(); got_s.delete(); exp_s.delete();
        got_done.delete(); exp_done.delete(); got_abt.delete(); exp_abt.delete();
        got_err.delete(); exp_err.delete();
        busy_cnt = 0;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] p, input int n);
        step();
        cfg_period      = p;
        cfg_num_samples = CW'(n);
        start = 1'b1;
        t0 = cyc;
        clear_logs();
        step();
        start = 1'b0;
    endtask

    task automatic add_w(input int c, input int a, input int d);
        exp_w.push_back('{c, 3'(a), 16'(d)});
    endtask

    task automatic add_s(input int c, input int idx);
        exp_s.push_back('{c, CW'(idx)});
    endtask

    task automatic cmp_int_q(input string tag, input int got[$], input int exp[$]);
        chk({tag, " count"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk($sformatf("%s[%0d] cycle", tag, i), got[i], exp[i]);
    endtask

    task automatic cmp_logs(input string tag);
        chk({tag, " nwrites"}, got_w.size(), exp_w.size());
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            chk($sformatf("%s wr[%0d] cycle", tag, i), got_w[i].c, exp_w[i].c);
            chk($sformatf("%s wr[%0d] addr", tag, i), got_w[i].a, exp_w[i].a);
            chk($sformatf("%s wr[%0d] data", tag, i), got_w[i].d, exp_w[i].d);
        end
        chk({tag, " nstrobes"}, got_s.size(), exp_s.size());
        for (int i = 0; i < got_s.size() && i < exp_s.size(); i++) begin
            chk($sformatf("%s stb[%0d] cycle", tag, i), got_s[i].c, exp_s[i].c);
            chk($sformatf("%s stb[%0d] index", tag, i), got_s[i].idx, exp_s[i].idx);
        end
        cmp_int_q({tag, " done"}, got_done, exp_done);
        cmp_int_q({tag, " aborted"}, got_abt, exp_abt);
        cmp_int_q({tag, " cfg_error"}, got_err, exp_err);
    endtask

    initial begin
        // Reset values
        step(); step();
        chk("rst busy", busy, 1'b0);
        chk("rst cs", tmr_chipselect, 1'b0);
        chk("rst write_n", tmr_write_n, 1'b1);
        chk("rst addr", tmr_address, 3'd0);
        chk("rst wdata", tmr_writedata, 16'h0);
        chk("rst done", done, 1'b0);
        chk("rst strobe", sample_strobe, 1'b0);
        reset = 1'b0;

        // P=9, N=3
        do_start(32'd9, 3);
        go_to(37);
        chk("t1 busy@37", busy, 1'b1);
        go_to(39);
        chk("t1 busy@39", busy, 1'b0);
        go_to(45);
        add_w(1, 2, 9); add_w(2, 3, 0); add_w(4, 1, 7);
        add_w(16, 0, 0); add_w(26, 0, 0); add_w(36, 0, 0); add_w(37, 1, 8);
        add_s(16, 0); add_s(26, 1); add_s(36, 2);
        exp_done.push_back(38);
        cmp_logs("t1");

        // P=0x10000, N=1
        do_reset();
        do_start(32'h0001_0000, 1);
        go_to(65550);
        add_w(1, 2, 16'h0000); add_w(2, 3, 16'h0001); add_w(4, 1, 7);
        add_w(65543, 0, 0); add_w(65544, 1, 8);
        add_s(65543, 0);
        exp_done.push_back(65545);
        cmp_logs("t2");

        // P=2 rejected
        do_reset();
        do_start(32'd2, 3);
        go_to(12);
        exp_err.push_back(1);
        cmp_logs("t3");
        chk("t3 busy cycles", busy_cnt, 0);

        // Free-run P=4, index wraps, then abort
        do_reset();
        do_start(32'd4, 0);
        go_to(108);
        abort = 1'b1;
        step();
        abort = 1'b0;
        go_to(120);
        add_w(1, 2, 4); add_w(2, 3, 0); add_w(4, 1, 7);
        for (int i = 0; i < 20; i++) begin
            add_w(11 + 5 * i, 0, 0);
            add_s(11 + 5 * i, i % 16);
        end
        add_w(109, 1, 8);
        exp_abt.push_back(110);
        cmp_logs("t4");

        // Abort in the same cycle the irq is high
        do_reset();
        do_start(32'd9, 3);
        go_to(15);
        chk("t5 irq@15", tmr_irq, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        go_to(25);
        add_w(1, 2, 9); add_w(2, 3, 0); add_w(4, 1, 7); add_w(16, 1, 8);
        exp_abt.push_back(17);
        cmp_logs("t5");

        // Second start during RUN is ignored
        do_reset();
        do_start(32'd9, 2);
        go_to(10);
        cfg_period = 32'd20;
        cfg_num_samples = CW'(5);
        start = 1'b1;
        step();
        start = 1'b0;
        go_to(35);
        add_w(1, 2, 9); add_w(2, 3, 0); add_w(4, 1, 7);
        add_w(16, 0, 0); add_w(26, 0, 0); add_w(27, 1, 8);
        add_s(16, 0); add_s(26, 1);
        exp_done.push_back(28);
        cmp_logs("t6");

        // Reset during RUN
        do_reset();
        do_start(32'd9, 3);
        go_to(20);
        chk("t7 busy@20", busy, 1'b1);
        reset = 1'b1;
        step();
        chk("t7 busy@21", busy, 1'b0);
        chk("t7 cs@21", tmr_chipselect, 1'b0);
        chk("t7 write_n@21", tmr_write_n, 1'b1);
        chk("t7 strobe@21", sample_strobe, 1'b0);
        reset = 1'b0;
        clear_logs();
        repeat (20) step();
        chk("t7 writes after reset", got_w.size(), 0);
        chk("t7 strobes after reset", got_s.size(), 0);
        chk("t7 busy after reset", busy_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
